riscv_wb_arbiter: RTL and testbench

- Shares the single register-file write port (enable_write_rd / rd_index / rd) between two writeback requesters: ALU/execute (alu_*) and load unit (mem_*).
- Uses a valid/ready handshake per requester and a registered output stage.
- Priority is fixed to the load unit, with a starvation counter that guarantees ALU progress.
- Sits between the execute/memory stages and the register file, in the core's writeback stage.

---
 rtl/riscv_wb_arbiter_pkg.sv | 20 ++
 rtl/riscv_wb_arbiter_if.sv | 47 ++++
 rtl/riscv_wb_scoreboard.sv | 43 ++++
 rtl/riscv_wb_arbiter.sv | 109 ++++++++++
 tb/tb_riscv_wb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared definitions for the writeback-port arbiter: register-file geometry,
// arbitration state and requester encodings.
package riscv_wb_arbiter_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        WB_MEM_PRI = 1'b0,
        WB_ALU_PRI = 1'b1
    } wb_arb_state_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Writeback bundle: two requesters, the register-file write port and the
// scoreboard issue/lookup signals. slave = arbiter side, master = stage side.
interface riscv_wb_arbiter_if #(
    parameter int XLEN = 32
);
    import riscv_wb_arbiter_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    reg_idx_t        alu_rd_index;
    logic [XLEN-1:0] alu_rd;

    logic            mem_valid;
    logic            mem_ready;
    reg_idx_t        mem_rd_index;
    logic [XLEN-1:0] mem_rd;

    logic            enable_write_rd;
    reg_idx_t        rd_index;
    logic [XLEN-1:0] rd;

    logic            issue_valid;
    reg_idx_t        issue_rd_index;
    reg_idx_t        rs1_index;
    reg_idx_t        rs2_index;
    logic            rs1_busy;
    logic            rs2_busy;

    modport slave (
        input  alu_valid, alu_rd_index, alu_rd,
        input  mem_valid, mem_rd_index, mem_rd,
        input  issue_valid, issue_rd_index, rs1_index, rs2_index,
        output alu_ready, mem_ready,
        output enable_write_rd, rd_index, rd,
        output rs1_busy, rs2_busy
    );

    modport master (
        output alu_valid, alu_rd_index, alu_rd,
        output mem_valid, mem_rd_index, mem_rd,
        output issue_valid, issue_rd_index, rs1_index, rs2_index,
        input  alu_ready, mem_ready,
        input  enable_write_rd, rd_index, rd,
        input  rs1_busy, rs2_busy
    );

endinterface

// File: rtl/riscv_wb_scoreboard.sv
// Busy vector of registers with an issued-but-uncommitted write, plus two
// combinational lookups. Set on issue, cleared on commit; set wins on a tie.
module riscv_wb_scoreboard
    import riscv_wb_arbiter_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     issue_valid,
    input  reg_idx_t issue_rd_index,
    input  logic     commit_en,
    input  reg_idx_t commit_index,
    input  reg_idx_t rs1_index,
    input  reg_idx_t rs2_index,
    output logic     rs1_busy,
    output logic     rs2_busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (commit_en) begin
            busy_d[commit_index] = 1'b0;
        end
        if (issue_valid && (issue_rd_index != '0)) begin
            busy_d[issue_rd_index] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // x0 is never set, but gate anyway so the lookup is correct by construction.
    assign rs1_busy = (rs1_index != '0) && busy_q[rs1_index];
    assign rs2_busy = (rs2_index != '0) && busy_q[rs2_index];

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Load-priority arbiter for the register-file write port with ALU anti-starvation
// and a one-cycle registered write stage. Optional busy scoreboard: RISCV_WB_SCOREBOARD_EN.
module riscv_wb_arbiter
    import riscv_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic               clock,
    input logic               reset,
    riscv_wb_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_arb_state_t   state_q;
    wb_arb_state_t   state_d;
    logic [3:0]      starve_q;
    logic [3:0]      starve_d;

    logic            alu_grant;
    logic            mem_grant;
    wb_src_t         grant_src;
    reg_idx_t        sel_index;
    logic [XLEN-1:0] sel_data;

    logic            wr_en_q;
    reg_idx_t        wr_index_q;
    logic [XLEN-1:0] wr_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= WB_MEM_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // A lost arbitration only counts when the ALU was actually waiting.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (alu_grant) begin
            starve_d = '0;
            state_d  = WB_MEM_PRI;
        end else if (mem_grant && bus.alu_valid) begin
            if (starve_q < LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
            if ((starve_q + 4'd1) >= LIMIT) begin
                state_d = WB_ALU_PRI;
            end
        end
    end

    always_comb begin
        alu_grant = bus.alu_valid && (!bus.mem_valid || (state_q == WB_ALU_PRI));
        mem_grant = bus.mem_valid && !alu_grant;
        grant_src = mem_grant ? WB_SRC_MEM : WB_SRC_ALU;
        sel_index = (grant_src == WB_SRC_MEM) ? bus.mem_rd_index : bus.alu_rd_index;
        sel_data  = (grant_src == WB_SRC_MEM) ? bus.mem_rd : bus.alu_rd;
    end

    assign bus.alu_ready = alu_grant;
    assign bus.mem_ready = mem_grant;

    // x0 transfers are consumed but never reach the write enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= (alu_grant || mem_grant) && (sel_index != '0);
            if (alu_grant || mem_grant) begin
                wr_index_q <= sel_index;
                wr_data_q  <= sel_data;
            end
        end
    end

    assign bus.enable_write_rd = wr_en_q;
    assign bus.rd_index        = wr_index_q;
    assign bus.rd              = wr_data_q;

`ifdef RISCV_WB_SCOREBOARD_EN
    riscv_wb_scoreboard u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (bus.issue_valid),
        .issue_rd_index (bus.issue_rd_index),
        .commit_en      (wr_en_q),
        .commit_index   (wr_index_q),
        .rs1_index      (bus.rs1_index),
        .rs2_index      (bus.rs2_index),
        .rs1_busy       (bus.rs1_busy),
        .rs2_busy       (bus.rs2_busy)
    );
`else
    logic unused_scoreboard;
    assign unused_scoreboard = ^{bus.issue_valid, bus.issue_rd_index,
                                 bus.rs1_index, bus.rs2_index};
    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios plus a random
// run checked against a loss-count model of the arbitration rules.
module tb_riscv_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 3;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    riscv_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    riscv_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid      = 1'b0;
        bus.alu_rd_index   = '0;
        bus.alu_rd         = '0;
        bus.mem_valid      = 1'b0;
        bus.mem_rd_index   = '0;
        bus.mem_rd         = '0;
        bus.issue_valid    = 1'b0;
        bus.issue_rd_index = '0;
        bus.rs1_index      = '0;
        bus.rs2_index      = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.enable_write_rd !== 1'b0 || bus.rd_index !== 5'd0 || bus.rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b idx=%0d rd=%h, expected 0/0/0",
                     bus.enable_write_rd, bus.rd_index, bus.rd);
        end
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got alu_ready=%b mem_ready=%b rs1_busy=%b, expected 0",
                     bus.alu_ready, bus.mem_ready, bus.rs1_busy);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_alu();
        bus.alu_valid    = 1'b1;
        bus.alu_rd_index = 5'd5;
        bus.alu_rd       = 32'h1234_5678;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_alu_ready: got alu=%b mem=%b, expected 1/0",
                     bus.alu_ready, bus.mem_ready);
        end
        step();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.enable_write_rd !== 1'b1 || bus.rd_index !== 5'd5 || bus.rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_alu_write: got en=%b idx=%0d rd=%h, expected 1/5/12345678",
                     bus.enable_write_rd, bus.rd_index, bus.rd);
        end
        step();
        checks++;
        if (bus.enable_write_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_alu_pulse: got en=%b, expected 0", bus.enable_write_rd);
        end
    endtask

    task automatic test_starvation();
        logic       exp_alu;
        logic [4:0] exp_idx;
        bus.alu_valid    = 1'b1;
        bus.alu_rd_index = 5'd1;
        bus.alu_rd       = 32'hAAAA_0001;
        bus.mem_valid    = 1'b1;
        bus.mem_rd_index = 5'd2;
        bus.mem_rd       = 32'hBBBB_0002;
        for (int i = 0; i < 8; i++) begin
            exp_alu = ((i % (LIMIT + 1)) == LIMIT);
            exp_idx = exp_alu ? 5'd1 : 5'd2;
            #1;
            checks++;
            if (bus.alu_ready !== exp_alu || bus.mem_ready !== !exp_alu) begin
                errors++;
                $display("FAIL starve_grant[%0d]: got alu=%b mem=%b, expected alu=%b",
                         i, bus.alu_ready, bus.mem_ready, exp_alu);
            end
            step();
            checks++;
            if (bus.enable_write_rd !== 1'b1 || bus.rd_index !== exp_idx) begin
                errors++;
                $display("FAIL starve_index[%0d]: got en=%b idx=%0d, expected 1/%0d",
                         i, bus.enable_write_rd, bus.rd_index, exp_idx);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_x0();
        bus.mem_valid    = 1'b1;
        bus.mem_rd_index = 5'd0;
        bus.mem_rd       = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got mem_ready=%b, expected 1", bus.mem_ready);
        end
        step();
        bus.mem_valid = 1'b0;
        checks++;
        if (bus.enable_write_rd !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got en=%b, expected 0", bus.enable_write_rd);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid    = (i < 3);
            bus.alu_rd_index = 5'(3 + i);
            bus.alu_rd       = 32'hC0DE_0000 + 32'(i);
            if (i > 0) begin
                checks++;
                if (bus.enable_write_rd !== 1'b1 || bus.rd_index !== 5'(2 + i) ||
                    bus.rd !== 32'hC0DE_0000 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_write[%0d]: got en=%b idx=%0d rd=%h, expected 1/%0d",
                             i, bus.enable_write_rd, bus.rd_index, bus.rd, 2 + i);
                end
            end
            step();
        end
        checks++;
        if (bus.enable_write_rd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got en=%b, expected 0", bus.enable_write_rd);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.alu_valid    = 1'b1;
        bus.alu_rd_index = 5'd7;
        bus.alu_rd       = 32'h0000_0777;
        step();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.enable_write_rd !== 1'b1 || bus.rd_index !== 5'd7) begin
            errors++;
            $display("FAIL rstmid_pending: got en=%b idx=%0d, expected 1/7",
                     bus.enable_write_rd, bus.rd_index);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.enable_write_rd !== 1'b0 || bus.rd_index !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async: got en=%b idx=%0d, expected 0/0",
                     bus.enable_write_rd, bus.rd_index);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.enable_write_rd !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after[%0d]: got en=%b idx=%0d, expected no write",
                         i, bus.enable_write_rd, bus.rd_index);
            end
        end
    endtask

    task automatic test_scoreboard();
        logic exp_busy;
`ifdef RISCV_WB_SCOREBOARD_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        bus.issue_valid    = 1'b1;
        bus.issue_rd_index = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        bus.rs1_index   = 5'd9;
        bus.rs2_index   = 5'd0;
        #1;
        checks++;
        if (bus.rs1_busy !== exp_busy || bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue: got rs1=%b rs2=%b, expected %b/0",
                     bus.rs1_busy, bus.rs2_busy, exp_busy);
        end
        bus.alu_valid    = 1'b1;
        bus.alu_rd_index = 5'd9;
        bus.alu_rd       = 32'h9999;
        step();
        bus.alu_valid      = 1'b0;
        bus.issue_valid    = 1'b1;
        bus.issue_rd_index = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        checks++;
        if (bus.rs1_busy !== exp_busy) begin
            errors++;
            $display("FAIL sb_set_wins: got rs1=%b, expected %b", bus.rs1_busy, exp_busy);
        end
        bus.alu_valid = 1'b1;
        step();
        bus.alu_valid = 1'b0;
        step();
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: got rs1=%b rs2=%b, expected 0/0", bus.rs1_busy, bus.rs2_busy);
        end
        idle_inputs();
        step();
    endtask

    // Model: count consecutive ALU losses (saturating); ALU wins alone or once
    // it has lost LIMIT times in a row.
    task automatic test_random();
        int          losses;
        logic        av, mv, a_pend, m_pend, exp_a, exp_m, exp_en, g;
        logic [4:0]  ai, mi, exp_idx;
        logic [31:0] ad, md, exp_dat;
        losses = 0;
        a_pend = 1'b0;
        m_pend = 1'b0;
        av = 1'b0; mv = 1'b0; ai = '0; mi = '0; ad = '0; md = '0;
        for (int i = 0; i < 400; i++) begin
            if (!a_pend) begin
                av = ($urandom_range(0, 2) != 0);
                ai = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ad = $urandom;
            end
            if (!m_pend) begin
                mv = ($urandom_range(0, 2) != 0);
                mi = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md = $urandom;
            end
            bus.alu_valid = av; bus.alu_rd_index = ai; bus.alu_rd = ad;
            bus.mem_valid = mv; bus.mem_rd_index = mi; bus.mem_rd = md;
            #1;
            exp_a = av && (!mv || losses >= LIMIT);
            exp_m = mv && !exp_a;
            checks++;
            if (bus.alu_ready !== exp_a || bus.mem_ready !== exp_m) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got alu=%b mem=%b, expected alu=%b mem=%b",
                         i, bus.alu_ready, bus.mem_ready, exp_a, exp_m);
            end
            if (exp_a) losses = 0;
            else if (exp_m && av && losses < LIMIT) losses++;
            g       = exp_a || exp_m;
            exp_idx = exp_a ? ai : mi;
            exp_dat = exp_a ? ad : md;
            exp_en  = g && (exp_idx != 5'd0);
            a_pend  = av && !exp_a;
            m_pend  = mv && !exp_m;
            step();
            checks++;
            if (bus.enable_write_rd !== exp_en ||
                (exp_en && (bus.rd_index !== exp_idx || bus.rd !== exp_dat))) begin
                errors++;
                $display("FAIL rand_write[%0d]: got en=%b idx=%0d rd=%h, expected en=%b idx=%0d rd=%h",
                         i, bus.enable_write_rd, bus.rd_index, bus.rd, exp_en, exp_idx, exp_dat);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_starvation();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        test_scoreboard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
